// File: rtl/conv_pkg.sv
// Shared encodings and sizing helpers for the convolution MAC datapath
// and the blocks that reuse its shift/saturate stage.
package conv_pkg;

  localparam logic [1:0] MODE_SAT      = 2'b00;
  localparam logic [1:0] MODE_SAT_RELU = 2'b01;
  localparam logic [1:0] MODE_WRAP     = 2'b10;

  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 32;
  endfunction

  function automatic int acc_w(
    input int bits,
    input int taps,
    input int guard
  );
    return 2 * bits + clog2(taps) + guard;
  endfunction

endpackage

// File: rtl/conv_sat_shift.sv
// Arithmetic right shift, optional ReLU, then clamp or wrap to BITS.
// Purely combinational so pooling can share it.
module conv_sat_shift
  import conv_pkg::*;
#(
  parameter int BITS    = 9,
  parameter int ACC_W   = 26,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc_in,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic        [1:0]         mode,
  output logic signed [BITS-1:0]    pixel,
  output logic                      sat
);

  localparam logic signed [ACC_W-1:0] PMAX =
    ACC_W'((1 << (BITS - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PMIN = ~PMAX;

  logic signed [ACC_W-1:0] s;

  always_comb begin
    s     = acc_in >>> shift;
    pixel = s[BITS-1:0];
    sat   = 1'b0;
    if (mode == MODE_SAT_RELU && s < 0) begin
      s     = '0;
      pixel = '0;
    end
    if (mode != MODE_WRAP) begin
      if (s > PMAX) begin
        pixel = PMAX[BITS-1:0];
        sat   = 1'b1;
      end else if (s < PMIN) begin
        pixel = PMIN[BITS-1:0];
        sat   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Three-stage multiply / adder-tree / channel-accumulate pipeline
// with a single global stall driven by the output handshake.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int ACC_GUARD   = 4,
  parameter int SHIFT_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_in,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [1:0]               cfg_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [BITS-1:0]   pixel_out,
  output logic                     out_sat
);

  localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_W = acc_w(BITS, N, ACC_GUARD);
  localparam int PW    = 2 * BITS;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic signed [PW-1:0] prod [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = PW'($signed(shift_in[i*BITS +: BITS]))
              * PW'($signed(kernel_in[i*BITS +: BITS]));
    end
  end

  logic                 s1_valid, s1_last;
  logic [SHIFT_W-1:0]   s1_shift;
  logic [1:0]           s1_mode;
  logic signed [PW-1:0] s1_prod [N];

  logic signed [ACC_W-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < N; i++) begin
      tree_sum = tree_sum + ACC_W'(s1_prod[i]);
    end
  end

  logic                    s2_valid, s2_last;
  logic [SHIFT_W-1:0]      s2_shift;
  logic [1:0]              s2_mode;
  logic signed [ACC_W-1:0] s2_sum;

  logic                    open;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [BITS-1:0]  res_pixel;
  logic                    res_sat;

  assign acc_next = (open ? acc : '0) + s2_sum;

  conv_sat_shift #(
    .BITS   (BITS),
    .ACC_W  (ACC_W),
    .SHIFT_W(SHIFT_W)
  ) u_sat (
    .acc_in(acc_next),
    .shift (s2_shift),
    .mode  (s2_mode),
    .pixel (res_pixel),
    .sat   (res_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_shift  <= '0;
      s1_mode   <= '0;
      for (int i = 0; i < N; i++) s1_prod[i] <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_shift  <= '0;
      s2_mode   <= '0;
      s2_sum    <= '0;
      acc       <= '0;
      open      <= 1'b0;
      out_valid <= 1'b0;
      pixel_out <= '0;
      out_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      s1_shift <= cfg_shift;
      s1_mode  <= cfg_mode;
      for (int i = 0; i < N; i++) s1_prod[i] <= prod[i];
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_shift <= s1_shift;
      s2_mode  <= s1_mode;
      s2_sum   <= tree_sum;
      out_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          out_valid <= 1'b1;
          pixel_out <= res_pixel;
          out_sat   <= res_sat;
          acc       <= '0;
          open      <= 1'b0;
        end else begin
          acc  <= acc_next;
          open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe: driver pushes expected pixels,
// a monitor pops them on every output handshake.
module tb_conv_mac_pipe;

  localparam int BITS = 9;
  localparam int N    = 9;
  localparam int NB   = N * BITS;

  logic                   clk = 0;
  logic                   rst_n = 0;
  logic                   in_valid = 0;
  logic                   in_ready;
  logic                   in_last = 0;
  logic [NB-1:0]          shift_in = '0;
  logic [NB-1:0]          kernel_in = '0;
  logic [4:0]             cfg_shift = '0;
  logic [1:0]             cfg_mode = '0;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [BITS-1:0] pixel_out;
  logic                   out_sat;

  conv_mac_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .shift_in (shift_in),
    .kernel_in(kernel_in),
    .cfg_shift(cfg_shift),
    .cfg_mode (cfg_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pixel_out(pixel_out),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [BITS-1:0] pix;
    logic                   sat;
  } exp_t;

  exp_t   sb[$];
  int     tests = 0;
  int     fails = 0;
  int     outs = 0;
  longint pkt_sum = 0;
  bit     stall_req = 0;
  bit     rand_rdy = 0;

  // out_ready has a single writer
  initial out_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    if (stall_req) out_ready = 1'b0;
    else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  task automatic check(input string name, input longint act,
                       input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint dot(input logic [NB-1:0] w,
                                 input logic [NB-1:0] k);
    longint s = 0;
    for (int i = 0; i < N; i++) begin
      logic signed [BITS-1:0] a, b;
      a = w[i*BITS +: BITS];
      b = k[i*BITS +: BITS];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic exp_t model(input longint total, input int sh,
                                 input int md);
    exp_t   e;
    longint s;
    s = total >>> sh;
    if (md == 1 && s < 0) s = 0;
    e.sat = 1'b0;
    if (md == 2) begin
      e.pix = s[BITS-1:0];
    end else if (s > 255) begin
      e.pix = 9'sd255;
      e.sat = 1'b1;
    end else if (s < -256) begin
      e.pix = -9'sd256;
      e.sat = 1'b1;
    end else begin
      e.pix = s[BITS-1:0];
    end
    return e;
  endfunction

  function automatic logic [NB-1:0] fill(input int v);
    logic [NB-1:0] r;
    for (int i = 0; i < N; i++) r[i*BITS +: BITS] = v[BITS-1:0];
    return r;
  endfunction

  function automatic logic [NB-1:0] rnd_vec();
    logic [NB-1:0] r;
    for (int i = 0; i < N; i++) r[i*BITS +: BITS] = BITS'($urandom);
    return r;
  endfunction

  task automatic send(input logic [NB-1:0] w, input logic [NB-1:0] k,
                      input logic last, input int sh, input int md);
    bit ok;
    int guard = 0;
    shift_in  = w;
    kernel_in = k;
    in_last   = last;
    cfg_shift = sh[4:0];
    cfg_mode  = md[1:0];
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 1000) begin
        $display("FAIL in_ready_timeout: got stuck expected accept");
        $fatal(1, "driver timeout");
      end
    end
    in_valid = 1'b0;
    pkt_sum += dot(w, k);
    if (last) begin
      sb.push_back(model(pkt_sum, sh, md));
      pkt_sum = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      outs++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got pixel %0d expected none",
                 pixel_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pixel", pixel_out, e.pix);
        check("out_sat", out_sat, e.sat);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    int lat;
    int base;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // zero window, latency measured in negedges after accept
    send(fill(0), fill(0), 1, 0, 0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, 3);
    drain();

    send(fill(1), fill(1), 1, 0, 0);
    send(fill(255), fill(255), 1, 0, 0);
    send(fill(255), fill(1), 1, 0, 2);
    send(fill(-256), fill(1), 1, 0, 0);
    send(fill(-256), fill(1), 1, 0, 1);
    drain();

    // three-beat packet, then clean accumulator
    base = outs;
    send(fill(1), fill(1), 0, 0, 0);
    send(fill(1), fill(1), 0, 0, 0);
    send(fill(1), fill(1), 1, 1, 0);
    drain();
    check("multi_beat_pulses", outs - base, 1);
    send(fill(1), fill(1), 1, 0, 0);
    drain();

    // back-to-back with a forced stall mid-stream
    base = outs;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(fill(1), fill(k), 1, 0, 0);
      end
      begin
        int n = 0;
        while (outs - base < 2 && n < 200) begin
          @(negedge clk);
          n++;
        end
        stall_req = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (out_valid) check("in_ready_stalled", in_ready, 0);
        end
        stall_req = 1'b0;
      end
    join
    drain();
    check("stream_count", outs - base, 6);

    // reset mid-packet discards the partial sum
    base = outs;
    send(fill(1), fill(1), 0, 0, 0);
    send(fill(1), fill(1), 0, 0, 0);
    idle(3);
    rst_n = 1'b0;
    pkt_sum = 0;
    #2;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    idle(1);
    rst_n = 1'b1;
    idle(5);
    check("no_output_after_rst", outs - base, 0);
    send(fill(1), fill(1), 1, 0, 0);
    drain();

    // randomized packets with random backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      int sh;
      int md;
      len = $urandom_range(1, 4);
      sh  = $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) sh = $urandom_range(0, 12);
      md  = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        send(rnd_vec(), rnd_vec(), (b == len - 1), sh, md);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_rdy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
Pipelined, handshaked successor to the single-window convolution multiplier. Each beat multiplies one KERNEL_SIZE x KERNEL_SIZE signed pixel window element-wise with a kernel and sums the products. Beats are accumulated across input channels until a beat marked last arrives. The accumulated sum is then scaled, saturated or wrapped, optionally ReLU'd, and emitted as one BITS-wide pixel. It sits between the line-buffer/window shifter and the output pixel FIFO.

Parameters:
BITS, 9, signed pixel/kernel element width.
KERNEL_SIZE, 3, window edge; N = KERNEL_SIZE*KERNEL_SIZE taps.
ACC_GUARD, 4, extra accumulator bits; ACC_W = 2*BITS + clog2(N) + ACC_GUARD. Caller guarantees at most 2^ACC_GUARD beats per packet.
SHIFT_W, 5, width of cfg_shift.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_last  in  1  final channel beat of packet
shift_in  in  N*BITS  window, element i at [i*BITS +: BITS], signed
kernel_in  in  N*BITS  kernel, same packing, signed
cfg_shift  in  SHIFT_W  arithmetic right shift applied to final sum
cfg_mode  in  2  00 SAT, 01 SAT_RELU, 10 WRAP, 11 treated as SAT
out_valid  out  1  result valid
out_ready  in  1  downstream accept
pixel_out  out  BITS  signed result
out_sat  out  1  result was clamped (SAT/SAT_RELU only)

Behaviour:
- Reset (async, rst_n=0): all stage valids, out_valid, out_sat = 0; pixel_out = 0; accumulator = 0, packet-open flag = 0. Any partial packet is discarded. in_ready = 1 while in reset.
- Global stall: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, every pipeline register, the accumulator and the outputs hold.
- Stages (no stall):
  - S1 registers N products (2*BITS signed), plus last, cfg_shift and cfg_mode.
  - S2 registers the adder-tree sum (ACC_W, sign-extended).
  - S3: if S2 valid, acc_next = (open ? acc : 0) + sum.
    - Not last: acc <= acc_next, open <= 1, no output.
    - Last: result computed from acc_next, out_valid <= 1, acc <= 0, open <= 0.
- Latency: a last beat accepted at cycle t gives out_valid at t+3. Full throughput is 1 beat/cycle. Bubbles are not collapsed.
- out_valid clears on handshake unless a new result loads in the same cycle.
- Config travels with each beat; the values on the last beat govern the result.
- Result computation:
  - s = acc_next >>> cfg_shift (floor).
  - SAT_RELU: s < 0 forces s = 0 first.
  - SAT/SAT_RELU: clamp to [-2^(BITS-1), 2^(BITS-1)-1]; out_sat = 1 iff clamped.
  - WRAP: pixel_out = s[BITS-1:0], out_sat = 0.
- cfg_shift >= ACC_W gives 0 or -1 per sign; no X.
- Simultaneous accept and emit is legal every cycle.

Decomposition:
- Shared package conv_pkg: mode encodings (MODE_SAT, MODE_SAT_RELU, MODE_WRAP), ACC_W function, clog2 helper.
- One sub-module, conv_sat_shift: combinational shift/ReLU/saturate/wrap, reused by the future pooling block.

Test Plan:
- All-zero window/kernel, one beat, last=1, shift 0, SAT -> pixel_out 0 at t+3, out_sat 0.
- All 1s, SAT -> 9. All 255s -> 585225 clamps to 255, out_sat 1. Same in WRAP, shift_in all 255, kernel all 1 (2295) -> 247.
- shift_in all -256, kernel all 1 -> -2304; SAT -> -256, out_sat 1. SAT_RELU -> 0, out_sat 0.
- Three beats all 1s, last on beat 3, cfg_shift 1 -> 27>>>1 = 13, exactly one out_valid pulse. Next single-beat packet starts from a clean accumulator.
- Back-to-back 6 single-beat packets (values 1..6 via kernel=k, window=1 -> 9k), out_ready low 5 cycles mid-stream:
  - in_ready low while stalled.
  - Outputs 9,18,27,36,45,54 in order, none lost or duplicated.
- rst_n asserted for 1 cycle after beat 2 of a 3-beat packet -> no output. A following 1-beat all-1s packet -> 9.
